// File: rtl/jtvigil_prio_colmix_if.sv
// CPU-side palette bus shared by the colour mixer and its host.
// The master drives address, data and strobes; the slave returns read data.
interface jtvigil_prio_colmix_if #(parameter int AW = 11);
  logic [AW-1:0] main_addr;
  logic [7:0]    main_dout;
  logic [7:0]    main_din;
  logic          main_rnw;
  logic          pal_cs;

  modport master(output main_addr, main_dout, main_rnw, pal_cs, input main_din);
  modport slave (input main_addr, main_dout, main_rnw, pal_cs, output main_din);
endinterface

// File: rtl/jtvigil_prio_colmix.sv
// N-layer priority colour mixer: picks the winning layer per pixel, then walks
// R/G/B out of a dual-port palette RAM and presents blank-masked registered RGB.
module jtvigil_prio_colmix #(
  parameter int              LAYERS  = 2,
  parameter int              PXLW    = 8,
  parameter int              CW      = 5,
  parameter logic [PXLW-1:0] BACKPAL = '0
)(
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   clk_cpu,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  jtvigil_prio_colmix_if.slave   main,
  input  logic [LAYERS*PXLW-1:0] lyr_pxl,
  input  logic [LAYERS-1:0]      gfx_en,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  output logic                   overrun
);
  localparam int LW = (LAYERS > 2) ? $clog2(LAYERS) : 1;
  localparam int AW = LW + 2 + PXLW;

  typedef enum logic [2:0] {IDLE, RD_R, RD_G, RD_B, CAP, LAST} st_t;

  logic [LAYERS-1:0][PXLW-1:0] pxl;
  logic [LAYERS-1:0]           opq, prm;
  logic [LW-1:0]               win_lyr_d, win_lyr_q;
  logic [PXLW-1:0]             win_idx_d, win_idx_q;
  logic [AW-1:0]               pal_addr_d, pal_addr_q;
  logic [7:0]                  pal_dout;
  logic [7:0]                  pal_ram [2**AW];
  logic [CW-1:0]               pre_r_q, pre_g_q, pre_b_q;
  logic [CW-1:0]               red_q, green_q, blue_q;
  logic                        hb_q, vb_q, ovr_q;
  logic [1:0]                  comp;
  logic                        cap_r, cap_g, cap_b;
  st_t                         st_q, st_d;

  assign pxl = lyr_pxl;

  generate
    for (genvar g = 0; g < LAYERS; g++) begin : g_lyr
      assign opq[g] = (|pxl[g][3:0]) & gfx_en[g];
      assign prm[g] = opq[g] & (&pxl[g][PXLW-1:PXLW-2]) & pxl[g][3];
    end
  endgenerate

  // Scan high-to-low so the lowest index wins; promoted layers override opaque ones.
  always_comb begin
    win_lyr_d = '0;
    win_idx_d = BACKPAL;
    for (int i = LAYERS-1; i >= 0; i--)
      if (opq[i]) begin
        win_lyr_d = LW'(i);
        win_idx_d = pxl[i];
      end
    for (int i = LAYERS-1; i >= 0; i--)
      if (prm[i]) begin
        win_lyr_d = LW'(i);
        win_idx_d = pxl[i];
      end
  end

  // Palette RAM: CPU port has absolute priority, video port is read-only.
  always_ff @(posedge clk_cpu) begin
    if (main.pal_cs && !main.main_rnw) pal_ram[main.main_addr] <= main.main_dout;
    main.main_din <= pal_ram[main.main_addr];
  end

  always_ff @(posedge clk) pal_dout <= pal_ram[pal_addr_q];

  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;

  always_comb begin
    st_d = st_q;
    if (pxl_cen) st_d = RD_R;
    else
      case (st_q)
        RD_R:    st_d = RD_G;
        RD_G:    st_d = RD_B;
        RD_B:    st_d = CAP;
        CAP:     st_d = LAST;
        LAST:    st_d = IDLE;
        default: st_d = IDLE;
      endcase
  end

  // Address is registered before the RAM, so data for RD_R lands during RD_B.
  always_comb begin
    comp  = 2'd0;
    cap_r = 1'b0;
    cap_g = 1'b0;
    cap_b = 1'b0;
    case (st_q)
      RD_G: comp  = 2'd1;
      RD_B: begin comp = 2'd2; cap_r = 1'b1; end
      CAP:  cap_g = 1'b1;
      LAST: cap_b = 1'b1;
      default: ;
    endcase
  end

  assign pal_addr_d = {win_lyr_q, comp, win_idx_q};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win_lyr_q  <= '0;
      win_idx_q  <= '0;
      pal_addr_q <= '0;
      pre_r_q    <= '0;
      pre_g_q    <= '0;
      pre_b_q    <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      pal_addr_q <= pal_addr_d;
      if (cap_r) pre_r_q <= pal_dout[CW-1:0];
      if (cap_g) pre_g_q <= pal_dout[CW-1:0];
      if (cap_b) pre_b_q <= pal_dout[CW-1:0];
      if (pxl_cen) begin
        win_lyr_q <= win_lyr_d;
        win_idx_q <= win_idx_d;
        red_q     <= (hb_q && vb_q) ? pre_r_q : '0;
        green_q   <= (hb_q && vb_q) ? pre_g_q : '0;
        blue_q    <= (hb_q && vb_q) ? pre_b_q : '0;
        hb_q      <= LHBL;
        vb_q      <= LVBL;
        if (st_q != IDLE) ovr_q <= 1'b1;
      end
    end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign LHBL_dly = hb_q;
  assign LVBL_dly = vb_q;
  assign overrun  = ovr_q;
endmodule

// File: tb/tb_jtvigil_prio_colmix.sv
// Directed bench for the colour mixer: palette preload, priority vector table,
// then hand sequences for blanking, overrun and mid-sequence reset.
module tb_jtvigil_prio_colmix;
  logic        clk = 0, clk_cpu = 0, rst = 1;
  logic        pxl_cen = 0, LHBL = 1, LVBL = 1;
  logic [15:0] lyr_pxl = '0;
  logic [1:0]  gfx_en = 2'b11;
  logic [4:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly, overrun;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;
  always #7 clk_cpu = ~clk_cpu;

  jtvigil_prio_colmix_if #(.AW(11)) bus();

  jtvigil_prio_colmix #(.LAYERS(2), .PXLW(8), .CW(5), .BACKPAL(8'h40)) dut (
    .rst(rst), .clk(clk), .clk_cpu(clk_cpu), .pxl_cen(pxl_cen),
    .LHBL(LHBL), .LVBL(LVBL), .main(bus), .lyr_pxl(lyr_pxl), .gfx_en(gfx_en),
    .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .overrun(overrun));

  typedef struct {
    logic [7:0] l0, l1;
    logic [1:0] en;
    logic [4:0] r, g, b;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] pa(input logic l, input logic [1:0] c, input logic [7:0] x);
    return {l, c, x};
  endfunction

  task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk_cpu);
    bus.main_addr = a; bus.main_dout = d; bus.main_rnw = 0; bus.pal_cs = 1;
    @(negedge clk_cpu);
    bus.pal_cs = 0; bus.main_rnw = 1;
  endtask

  task automatic wr_rgb(input logic l, input logic [7:0] x, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
    cpu_wr(pa(l, 2'd0, x), r);
    cpu_wr(pa(l, 2'd1, x), g);
    cpu_wr(pa(l, 2'd2, x), b);
  endtask

  // One pxl_cen cycle followed by `gap` cycles with pxl_cen low; starts and ends on a negedge.
  task automatic pulse(input int gap);
    pxl_cen = 1;
    @(negedge clk);
    pxl_cen = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic set_px(input logic [7:0] l0, input logic [7:0] l1, input logic [1:0] en);
    lyr_pxl = {l1, l0};
    gfx_en  = en;
  endtask

  initial begin
    bus.main_addr = '0; bus.main_dout = '0; bus.main_rnw = 1; bus.pal_cs = 0;
    vt[0]  = '{8'h00, 8'h25, 2'b11, 5'h1F, 5'h0A, 5'h03};
    vt[1]  = '{8'h12, 8'hCB, 2'b11, 5'h05, 5'h06, 5'h07};
    vt[2]  = '{8'h12, 8'h8B, 2'b11, 5'h08, 5'h09, 5'h0C};
    vt[3]  = '{8'h00, 8'h00, 2'b11, 5'h11, 5'h12, 5'h13};
    vt[4]  = '{8'h12, 8'h25, 2'b10, 5'h1F, 5'h0A, 5'h03};
    vt[5]  = '{8'hF0, 8'h25, 2'b11, 5'h1F, 5'h0A, 5'h03};
    vt[6]  = '{8'hF0, 8'hC0, 2'b11, 5'h11, 5'h12, 5'h13};
    vt[7]  = '{8'hCB, 8'hCB, 2'b11, 5'h15, 5'h16, 5'h17};
    vt[8]  = '{8'h12, 8'hC8, 2'b11, 5'h1A, 5'h1B, 5'h1C};
    vt[9]  = '{8'h12, 8'hC4, 2'b11, 5'h08, 5'h09, 5'h0C};
    vt[10] = '{8'h12, 8'hCB, 2'b01, 5'h08, 5'h09, 5'h0C};
    vt[11] = '{8'h12, 8'hCB, 2'b00, 5'h11, 5'h12, 5'h13};

    repeat (3) @(negedge clk);
    chk("rst_red", red, 0);
    chk("rst_green", green, 0);
    chk("rst_blue", blue, 0);
    chk("rst_lhbl_dly", LHBL_dly, 0);
    chk("rst_lvbl_dly", LVBL_dly, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;

    wr_rgb(1'b1, 8'h25, 8'h1F, 8'h0A, 8'h03);
    wr_rgb(1'b1, 8'hCB, 8'h05, 8'h06, 8'h07);
    wr_rgb(1'b0, 8'h12, 8'h08, 8'h09, 8'hEC);  // upper bits dropped at CW=5
    wr_rgb(1'b0, 8'h40, 8'h11, 8'h12, 8'h13);
    wr_rgb(1'b1, 8'h8B, 8'h01, 8'h02, 8'h04);
    wr_rgb(1'b0, 8'hCB, 8'h15, 8'h16, 8'h17);
    wr_rgb(1'b1, 8'hC8, 8'h1A, 8'h1B, 8'h1C);
    wr_rgb(1'b1, 8'h12, 8'h1E, 8'h1D, 8'h1E);

    @(negedge clk_cpu);
    bus.main_addr = pa(1'b1, 2'd0, 8'h25); bus.main_rnw = 1; bus.pal_cs = 1;
    @(negedge clk_cpu);
    chk("cpu_read", bus.main_din, 8'h1F);
    bus.pal_cs = 0;

    @(negedge clk);
    set_px(8'h00, 8'h25, 2'b11);
    pulse(5);
    chk("first_px_blank", red, 0);
    chk("first_px_lhbl_dly", LHBL_dly, 1);

    for (int i = 0; i < 12; i++) begin
      set_px(vt[i].l0, vt[i].l1, vt[i].en);
      pulse(5);
      pulse(5);
      chk($sformatf("vec%0d_r", i), red, vt[i].r);
      chk($sformatf("vec%0d_g", i), green, vt[i].g);
      chk($sformatf("vec%0d_b", i), blue, vt[i].b);
    end

    // Horizontal blank on one pixel masks that pixel's colour one pxl_cen later.
    set_px(8'h00, 8'h25, 2'b11);
    LHBL = 0;
    pulse(5);
    chk("hb_dly_low", LHBL_dly, 0);
    LHBL = 1;
    pulse(5);
    chk("hb_red_masked", red, 0);
    chk("hb_green_masked", green, 0);
    chk("hb_dly_high", LHBL_dly, 1);
    pulse(5);
    chk("hb_red_back", red, 5'h1F);
    LVBL = 0;
    pulse(5);
    LVBL = 1;
    pulse(5);
    chk("vb_blue_masked", blue, 0);

    chk("ovr_gap5", overrun, 0);
    pulse(3);
    pulse(3);
    chk("ovr_gap3", overrun, 1);
    pulse(5);
    pulse(5);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_recover_red", red, 5'h1F);

    // Reset while the sequencer is in RD_G.
    pxl_cen = 1;
    @(negedge clk);
    pxl_cen = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_red", red, 0);
    chk("midrst_blue", blue, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_lhbl_dly", LHBL_dly, 0);
    @(negedge clk);
    rst = 0;
    pulse(5);
    chk("postrst_px1", red, 0);
    pulse(5);
    chk("postrst_px2_r", red, 5'h1F);
    chk("postrst_px2_g", green, 5'h0A);
    chk("postrst_px2_b", blue, 5'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
